usr_serial_controller: RTL

//  Sequencer that drives a 4-bit-style universal shift register (USR) through its

---
 rtl/usr_serial_controller_pkg.sv | 36 +++
 rtl/usr_serial_controller_if.sv | 23 ++
 rtl/usr_serial_controller_bit_timer.sv | 36 +++
 rtl/usr_serial_controller.sv | 106 ++++++++++
 4 files changed

// File: rtl/usr_serial_controller_pkg.sv
// Shared types for the USR transfer sequencer: USR mode selects, command opcodes,
// FSM state encoding and small opcode decode helpers.
package usr_serial_controller_pkg;

  // SHR moves data toward the MSB (serial in -> bit 0), SHL toward the LSB.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OP_TX   = 2'b00,
    OP_RX   = 2'b01,
    OP_XFER = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Reserved opcode behaves as TX: loads the command word, shifts in zeros.
  function automatic logic op_loads_data(input op_e op);
    return op != OP_RX;
  endfunction

  function automatic logic op_samples_in(input op_e op);
    return (op == OP_RX) || (op == OP_XFER);
  endfunction

endpackage

// File: rtl/usr_serial_controller_if.sv
// Command / response channel between a command master and the USR sequencer.
interface usr_serial_controller_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/usr_serial_controller_bit_timer.sv
// Bit-period divider and shifted-bit counter; flags the shift cycle and the final bit.
module usr_serial_controller_bit_timer #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_start,
  input  logic i_run,
  output logic o_shift_pulse,
  output logic o_last_bit
);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             w_div_term;

  assign w_div_term    = (r_div_cnt == DIV_LAST);
  assign o_shift_pulse = i_run && w_div_term;
  assign o_last_bit    = (r_bit_cnt == BIT_LAST);

  // bit_cnt saturates at the last bit; the FSM leaves SHIFT on that pulse.
  always_ff @(posedge i_clk) begin
    if (i_clear || i_start) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (i_run) begin
      r_div_cnt <= w_div_term ? '0 : r_div_cnt + 1'b1;
      if (w_div_term && !o_last_bit) r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/usr_serial_controller.sv
// Sequences an external universal shift register through load/shift/hold modes to run
// one TX, RX or full-duplex serial transfer per command and return the final word.
module usr_serial_controller
  import usr_serial_controller_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                    i_clk,
  input  logic                    i_clr_n,
  input  logic                    i_abort,
  usr_serial_controller_if.slave  bus,
  input  logic                    i_ser_in,
  output logic                    o_ser_out,
  output logic                    o_ser_out_vld,
  output logic                    o_busy,
  output logic                    o_usr_s1,
  output logic                    o_usr_s0,
  output logic [WIDTH-1:0]        o_usr_p_in,
  output logic                    o_usr_in,
  input  logic [WIDTH-1:0]        i_usr_out
);
  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic             r_dir;
  logic [WIDTH-1:0] r_data;
  mode_e            w_mode;
  logic             w_shift_pulse;
  logic             w_last_bit;

  usr_serial_controller_bit_timer #(
    .WIDTH        (WIDTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .i_clk         (i_clk),
    .i_clear       (!i_clr_n || i_abort),
    .i_start       (r_state == ST_LOAD),
    .i_run         (r_state == ST_SHIFT),
    .o_shift_pulse (w_shift_pulse),
    .o_last_bit    (w_last_bit)
  );

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (bus.cmd_valid && bus.cmd_ready) begin
      r_op   <= op_e'(bus.cmd_op);
      r_dir  <= bus.cmd_dir;
      r_data <= bus.cmd_data;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.cmd_valid) w_next = ST_LOAD;
        ST_LOAD:  w_next = ST_SHIFT;
        ST_SHIFT: if (w_shift_pulse && w_last_bit) w_next = ST_DONE;
        ST_DONE:  if (bus.rsp_ready) w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Reset forces LOAD of zero so the external USR clears on the same edge.
  always_comb begin
    w_mode        = MODE_HOLD;
    o_usr_p_in    = '0;
    o_usr_in      = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    if (!i_clr_n) begin
      w_mode = MODE_LOAD;
    end else if (!i_abort) begin
      case (r_state)
        ST_IDLE: bus.cmd_ready = 1'b1;
        ST_LOAD: begin
          w_mode     = MODE_LOAD;
          o_usr_p_in = op_loads_data(r_op) ? r_data : '0;
        end
        ST_SHIFT: begin
          if (w_shift_pulse) begin
            w_mode   = r_dir ? MODE_SHL : MODE_SHR;
            o_usr_in = op_samples_in(r_op) && i_ser_in;
          end
        end
        ST_DONE: bus.rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_usr_s1      = w_mode[1];
  assign o_usr_s0      = w_mode[0];
  assign bus.rsp_data  = i_usr_out;
  assign o_ser_out     = r_dir ? i_usr_out[0] : i_usr_out[WIDTH-1];
  assign o_ser_out_vld = (r_state == ST_SHIFT);
  assign o_busy        = (r_state != ST_IDLE);
endmodule
